dmem_arbiter: RTL and testbench

- Shares the single-port, synchronous-read data memory between two requesters: the AVR CPU data port and a DMA/debug master.
- Sits between avr_cpu, the DMA master and data_memory.
- Grants at most one access per cycle and routes read data back to the owner one cycle after the grant.
- Stalls the CPU when it loses arbitration.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arb_return.sv | 71 +++++++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter:
//   - rt_tag_e : owner of the read return pending in the next cycle
//   - owner_e  : requester identity, used by the round-robin last-owner bit
//   - DATA_W   : data memory byte width
//   - MAX_CPU_BURST_DEF : default CPU burst length before DMA is forced
package dmem_arb_pkg;

  localparam int DATA_W            = 8;
  localparam int MAX_CPU_BURST_DEF = 4;

  typedef enum logic [1:0] {
    RT_IDLE = 2'd0,
    RT_CPU  = 2'd1,
    RT_DMA  = 2'd2
  } rt_tag_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the CPU data port, the DMA/debug port and the data_memory port.
//   slave  : the arbiter's view (requests in, grants/read data/memory drive out)
//   master : the surrounding system's view (CPU, DMA master and data_memory)
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata, cpu_stall, cpu_rdata, cpu_rvalid
//   dma_req/dma_we/dma_addr/dma_wdata, dma_gnt,   dma_rdata, dma_rvalid
//   mem_addr/mem_we/mem_wdata to the memory, mem_rdata from it
interface dmem_arbiter_if #(
  parameter int AW = 11
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_stall;
  logic [7:0]    cpu_rdata;
  logic          cpu_rvalid;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_wdata;
  logic          dma_gnt;
  logic [7:0]    dma_rdata;
  logic          dma_rvalid;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_return.sv
// dmem_arb_return
// Read-return pipeline: registers who owns the read issued this cycle and,
// one cycle later, steers the memory's registered read data to that owner.
// The non-owner's rdata keeps the last byte it was handed.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   grant_cpu, cpu_we     CPU grant this cycle and its direction
//   grant_dma, dma_we     DMA grant this cycle and its direction
//   mem_rdata             memory read data (valid the cycle after the read grant)
//   cpu_rdata/cpu_rvalid  CPU read return
//   dma_rdata/dma_rvalid  DMA read return
module dmem_arb_return
  import dmem_arb_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              grant_cpu,
  input  logic              cpu_we,
  input  logic              grant_dma,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid
);

  rt_tag_e           tag_p0;
  rt_tag_e           tag_next;
  logic [DATA_W-1:0] cpu_hold_p0;
  logic [DATA_W-1:0] dma_hold_p0;

  // Writes and idle cycles produce no return.
  always_comb begin
    tag_next = RT_IDLE;
    if (grant_cpu && !cpu_we) begin
      tag_next = RT_CPU;
    end else if (grant_dma && !dma_we) begin
      tag_next = RT_DMA;
    end
  end

  // Stage p0: owner of the read launched in the previous cycle.
  // An asynchronous reset here drops any read still in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag_p0 <= RT_IDLE;
    end else begin
      tag_p0 <= tag_next;
    end
  end

  // Capture the returned byte so each side keeps its last value afterwards.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cpu_hold_p0 <= '0;
      dma_hold_p0 <= '0;
    end else begin
      if (tag_p0 == RT_CPU) cpu_hold_p0 <= mem_rdata;
      if (tag_p0 == RT_DMA) dma_hold_p0 <= mem_rdata;
    end
  end

  always_comb begin
    cpu_rvalid = (tag_p0 == RT_CPU);
    dma_rvalid = (tag_p0 == RT_DMA);
    cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold_p0;
    dma_rdata  = dma_rvalid ? mem_rdata : dma_hold_p0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port synchronous-read data memory between the AVR CPU
// data port and a DMA/debug master. At most one access is granted per cycle;
// read data returns to the owner one cycle after its grant.
// Default policy: CPU priority, but after MAX_CPU_BURST consecutive CPU grants
// with DMA waiting, the DMA request is forced through.
// Build option DMEM_ARB_RR_EN: replaces the priority/burst guard with a 1-bit
// last-owner register; on contention the requester not granted last wins.
// Ports:
//   CLK    system clock (posedge)
//   RST_N  asynchronous active-low reset; mem_we forced 0 while low
//   bus    dmem_arbiter_if.slave - CPU port, DMA port and memory port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW            = 11,
  parameter int MAX_CPU_BURST = MAX_CPU_BURST_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  dmem_arbiter_if.slave   bus
);

  logic          grant_cpu;
  logic          grant_dma;
  logic [AW-1:0] mem_addr_c;
  logic [AW-1:0] addr_p0;

`ifdef DMEM_ARB_RR_EN
  owner_e last_p0;

  always_comb begin
    grant_cpu = bus.cpu_req & (~bus.dma_req | (last_p0 == OWN_DMA));
    grant_dma = bus.dma_req & (~bus.cpu_req | (last_p0 == OWN_CPU));
  end

  // Stage p0: last owner; reset favours the CPU on the first contention.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_p0 <= OWN_DMA;
    end else if (grant_cpu) begin
      last_p0 <= OWN_CPU;
    end else if (grant_dma) begin
      last_p0 <= OWN_DMA;
    end
  end
`else
  localparam logic [3:0] BURST_MAX = 4'(MAX_CPU_BURST);

  logic [3:0] burst_cnt_p0;
  logic       force_dma;

  always_comb begin
    force_dma = bus.dma_req & (burst_cnt_p0 == BURST_MAX);
    grant_cpu = bus.cpu_req & ~force_dma;
    grant_dma = bus.dma_req & (~bus.cpu_req | force_dma);
  end

  // Stage p0: CPU grants taken while DMA waits, saturating at BURST_MAX.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      burst_cnt_p0 <= '0;
    end else if (!bus.dma_req || grant_dma) begin
      burst_cnt_p0 <= '0;
    end else if (grant_cpu && (burst_cnt_p0 != BURST_MAX)) begin
      burst_cnt_p0 <= burst_cnt_p0 + 4'd1;
    end
  end
`endif

  // Memory mux: the granted requester drives the memory directly in its grant
  // cycle; otherwise the address parks on the last granted one.
  always_comb begin
    mem_addr_c    = addr_p0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = bus.cpu_wdata;
    if (grant_cpu) begin
      mem_addr_c    = bus.cpu_addr;
      bus.mem_we    = bus.cpu_we;
    end else if (grant_dma) begin
      mem_addr_c    = bus.dma_addr;
      bus.mem_we    = bus.dma_we;
      bus.mem_wdata = bus.dma_wdata;
    end
    if (!RST_N) bus.mem_we = 1'b0;
  end

  assign bus.mem_addr  = mem_addr_c;
  assign bus.cpu_stall = bus.cpu_req & ~grant_cpu;
  assign bus.dma_gnt   = grant_dma;

  // Stage p0: parked memory address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_p0 <= '0;
    end else begin
      addr_p0 <= mem_addr_c;
    end
  end

  dmem_arb_return u_return (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .grant_cpu  (grant_cpu),
    .cpu_we     (bus.cpu_we),
    .grant_dma  (grant_dma),
    .dma_we     (bus.dma_we),
    .mem_rdata  (bus.mem_rdata),
    .cpu_rdata  (bus.cpu_rdata),
    .cpu_rvalid (bus.cpu_rvalid),
    .dma_rdata  (bus.dma_rdata),
    .dma_rvalid (bus.dma_rvalid)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with a behavioural data_memory and a
// transaction-level reference model (who wins, what the memory holds, which
// read is outstanding). Works with and without DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  localparam int AW   = 11;
  localparam int MAXB = 4;
  localparam int DEPTH = 1 << AW;

  logic CLK;
  logic RST_N;

  dmem_arbiter_if #(.AW(AW)) bus ();

  dmem_arbiter #(.AW(AW), .MAX_CPU_BURST(MAXB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Environment memory: registered read, write in the grant cycle.
  logic [7:0]    ram [DEPTH];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;

  always @(posedge CLK) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_vec;
  int n_err;

  // Reference model state
  logic [7:0]    ref_mem [DEPTH];
  int            m_burst;
  bit            m_last_dma;
  int            m_pend;        // 0 none, 1 CPU, 2 DMA read outstanding
  logic [7:0]    m_pend_data;
  logic [7:0]    m_hold_cpu;
  logic [7:0]    m_hold_dma;
  logic [AW-1:0] m_addr;

  // Predictions for the current cycle
  int            exp_win;       // 0 none, 1 CPU, 2 DMA
  logic          exp_stall, exp_gnt, exp_we, exp_crv, exp_drv;
  logic [AW-1:0] exp_addr;
  logic [7:0]    exp_wdata, exp_crd, exp_drd;

  task automatic model_reset();
    m_burst = 0; m_last_dma = 1'b1; m_pend = 0;
    m_pend_data = '0; m_hold_cpu = '0; m_hold_dma = '0; m_addr = '0;
  endtask

  task automatic predict();
    if (!bus.cpu_req && !bus.dma_req) exp_win = 0;
    else if (!bus.dma_req) exp_win = 1;
    else if (!bus.cpu_req) exp_win = 2;
    else begin
`ifdef DMEM_ARB_RR_EN
      exp_win = m_last_dma ? 1 : 2;
`else
      exp_win = (m_burst >= MAXB) ? 2 : 1;
`endif
    end
    exp_stall = bus.cpu_req && (exp_win != 1);
    exp_gnt   = (exp_win == 2);
    exp_we    = RST_N && (((exp_win == 1) && bus.cpu_we) || ((exp_win == 2) && bus.dma_we));
    exp_addr  = (exp_win == 1) ? bus.cpu_addr : (exp_win == 2) ? bus.dma_addr : m_addr;
    exp_wdata = (exp_win == 2) ? bus.dma_wdata : bus.cpu_wdata;
    exp_crv   = (m_pend == 1);
    exp_drv   = (m_pend == 2);
    exp_crd   = exp_crv ? m_pend_data : m_hold_cpu;
    exp_drd   = exp_drv ? m_pend_data : m_hold_dma;
  endtask

  task automatic commit();
    if (m_pend == 1) m_hold_cpu = m_pend_data;
    if (m_pend == 2) m_hold_dma = m_pend_data;
    m_pend = 0;
    if (exp_win == 1) begin
      if (bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
      else begin m_pend = 1; m_pend_data = ref_mem[bus.cpu_addr]; end
      m_addr = bus.cpu_addr; m_last_dma = 1'b0;
    end else if (exp_win == 2) begin
      if (bus.dma_we) ref_mem[bus.dma_addr] = bus.dma_wdata;
      else begin m_pend = 2; m_pend_data = ref_mem[bus.dma_addr]; end
      m_addr = bus.dma_addr; m_last_dma = 1'b1;
    end
    if (!bus.dma_req || exp_win == 2) m_burst = 0;
    else if (exp_win == 1 && m_burst < MAXB) m_burst = m_burst + 1;
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [7:0] cwd, input logic dreq, input logic dwe,
                       input logic [AW-1:0] daddr, input logic [7:0] dwd);
    @(negedge CLK);
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
    bus.dma_req = dreq; bus.dma_we = dwe; bus.dma_addr = daddr; bus.dma_wdata = dwd;
    #1;
    predict();
  endtask

  task automatic preload_memory();
    logic [7:0] v;
    RST_N = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    pre_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      if (i == 'h7FF) v = 8'h3C;
      if (i == 'h020) v = 8'h11;
      if (i == 'h021) v = 8'h22;
      @(negedge CLK);
      pre_addr = AW'(i); pre_data = v; ref_mem[i] = v;
    end
    @(negedge CLK);
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 'h010, 8'h5A, 0, 0, '0, '0);
      n_vec++;
      if ({bus.mem_we, bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_stall} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_ctrl cyc%0d got we/crv/drv/stall=%b exp=0000", i,
                 {bus.mem_we, bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_stall});
      end
      n_vec++;
      if ({bus.cpu_rdata, bus.dma_rdata} !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_rdata cyc%0d got cpu=%h dma=%h exp=00/00", i, bus.cpu_rdata, bus.dma_rdata);
      end
    end
    #2 RST_N = 1'b1;
    #1 predict();
    n_vec++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'('h010)) begin
      n_err++;
      $display("FAIL reset_release_grant got we=%b addr=%h exp we=1 addr=010", bus.mem_we, bus.mem_addr);
    end
    commit();
  endtask

  task automatic test_cpu_only();
    drive(1, 1, 'h010, 8'hA5, 0, 0, '0, '0);
    n_vec++;
    if (bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'hA5) begin
      n_err++;
      $display("FAIL cpu_write got stall=%b we=%b wdata=%h exp 0/1/a5", bus.cpu_stall, bus.mem_we, bus.mem_wdata);
    end
    commit();
    drive(1, 0, 'h010, 8'h00, 0, 0, '0, '0);
    n_vec++;
    if (bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_read_issue got stall=%b we=%b rvalid=%b exp 0/0/0", bus.cpu_stall, bus.mem_we, bus.cpu_rvalid);
    end
    commit();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    n_vec++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hA5 || bus.mem_addr !== AW'('h010)) begin
      n_err++;
      $display("FAIL cpu_read_return got rvalid=%b rdata=%h addr=%h exp 1/a5/010",
               bus.cpu_rvalid, bus.cpu_rdata, bus.mem_addr);
    end
    commit();
  endtask

  task automatic test_dma_only();
    drive(0, 0, '0, '0, 1, 0, 'h7FF, '0);
    n_vec++;
    if (bus.dma_gnt !== 1'b1 || bus.mem_addr !== AW'('h7FF) || bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL dma_read_issue got gnt=%b addr=%h we=%b exp 1/7ff/0", bus.dma_gnt, bus.mem_addr, bus.mem_we);
    end
    commit();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    n_vec++;
    if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 8'h3C || bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 8'hA5) begin
      n_err++;
      $display("FAIL dma_read_return got drv=%b drd=%h crv=%b crd=%h exp 1/3c/0/a5",
               bus.dma_rvalid, bus.dma_rdata, bus.cpu_rvalid, bus.cpu_rdata);
    end
    commit();
  endtask

  task automatic test_interleaved();
    drive(1, 0, 'h020, '0, 0, 0, '0, '0);
    commit();
    drive(0, 0, '0, '0, 1, 0, 'h021, '0);
    n_vec++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h11 || bus.dma_rvalid !== 1'b0 || bus.dma_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL interleave_cpu got crv=%b crd=%h drv=%b gnt=%b exp 1/11/0/1",
               bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_gnt);
    end
    commit();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    n_vec++;
    if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 8'h22 || bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 8'h11) begin
      n_err++;
      $display("FAIL interleave_dma got drv=%b drd=%h crv=%b crd=%h exp 1/22/0/11",
               bus.dma_rvalid, bus.dma_rdata, bus.cpu_rvalid, bus.cpu_rdata);
    end
    commit();
  endtask

  task automatic test_contention();
    bit            pat [10];
    logic [AW-1:0] ca, da;
`ifdef DMEM_ARB_RR_EN
    pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    // A lone DMA write leaves the guard cleared and the CPU due on contention.
    drive(0, 0, '0, '0, 1, 1, 'h100, 8'h77);
    commit();
    ca = 'h040; da = 'h080;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, ca, '0, 1, 0, da, '0);
      n_vec++;
      if (bus.dma_gnt !== pat[i] || bus.cpu_stall !== pat[i]) begin
        n_err++;
        $display("FAIL contention_pattern cyc%0d got gnt=%b stall=%b exp %b", i, bus.dma_gnt, bus.cpu_stall, pat[i]);
      end
      n_vec++;
      if ({bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, bus.dma_rdata} !== {exp_crv, exp_drv, exp_crd, exp_drd}) begin
        n_err++;
        $display("FAIL contention_return cyc%0d got %b/%b/%h/%h exp %b/%b/%h/%h", i,
                 bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, bus.dma_rdata, exp_crv, exp_drv, exp_crd, exp_drd);
      end
      if (exp_win == 1) ca = ca + 1'b1;
      if (exp_win == 2) da = da + 1'b1;
      commit();
    end
  endtask

  task automatic test_mid_read_reset();
    drive(1, 0, 'h020, '0, 0, 0, '0, '0);
    #1 RST_N = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (bus.cpu_rvalid !== 1'b0 || bus.mem_we !== 1'b0 || bus.cpu_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL midreset_async got crv=%b we=%b crd=%h exp 0/0/00", bus.cpu_rvalid, bus.mem_we, bus.cpu_rdata);
    end
    @(posedge CLK);
    #1;
    n_vec++;
    if (bus.cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_edge got crv=%b exp 0", bus.cpu_rvalid);
    end
    @(negedge CLK);
    bus.cpu_req = 0; bus.dma_req = 0;
    RST_N = 1'b1;
    #1 predict();
    commit();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, '0, '0, 0, 0, '0, '0);
      n_vec++;
      if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0 || bus.mem_addr !== '0) begin
        n_err++;
        $display("FAIL midreset_after cyc%0d got crv=%b drv=%b addr=%h exp 0/0/000",
                 i, bus.cpu_rvalid, bus.dma_rvalid, bus.mem_addr);
      end
      commit();
    end
  endtask

  task automatic test_random();
    logic          creq = 0, cwe = 0, dreq = 0, dwe = 0;
    logic [AW-1:0] caddr = '0, daddr = '0;
    logic [7:0]    cwd = '0, dwd = '0;
    bit            hold_c = 0, hold_d = 0;
    for (int i = 0; i < 600; i++) begin
      if (!hold_c) begin
        creq = ($urandom_range(0, 3) != 0); cwe = $urandom_range(0, 1) == 1;
        caddr = AW'($urandom_range(0, 15)); cwd = 8'($urandom);
      end
      if (!hold_d) begin
        dreq = ($urandom_range(0, 2) != 0); dwe = $urandom_range(0, 1) == 1;
        daddr = AW'($urandom_range(0, 15)); dwd = 8'($urandom);
      end
      drive(creq, cwe, caddr, cwd, dreq, dwe, daddr, dwd);
      n_vec++;
      if ({bus.cpu_stall, bus.dma_gnt, bus.mem_we, bus.cpu_rvalid, bus.dma_rvalid} !==
          {exp_stall, exp_gnt, exp_we, exp_crv, exp_drv}) begin
        n_err++;
        $display("FAIL rand_ctrl cyc%0d got stall/gnt/we/crv/drv=%b exp %b", i,
                 {bus.cpu_stall, bus.dma_gnt, bus.mem_we, bus.cpu_rvalid, bus.dma_rvalid},
                 {exp_stall, exp_gnt, exp_we, exp_crv, exp_drv});
      end
      n_vec++;
      if (bus.mem_addr !== exp_addr || (exp_we && bus.mem_wdata !== exp_wdata)) begin
        n_err++;
        $display("FAIL rand_membus cyc%0d got addr=%h wdata=%h exp addr=%h wdata=%h", i,
                 bus.mem_addr, bus.mem_wdata, exp_addr, exp_wdata);
      end
      n_vec++;
      if (bus.cpu_rdata !== exp_crd || bus.dma_rdata !== exp_drd) begin
        n_err++;
        $display("FAIL rand_rdata cyc%0d got cpu=%h dma=%h exp cpu=%h dma=%h", i,
                 bus.cpu_rdata, bus.dma_rdata, exp_crd, exp_drd);
      end
      hold_c = exp_stall;
      hold_d = dreq && !exp_gnt;
      commit();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    preload_memory();
    test_reset();
    test_cpu_only();
    test_dma_only();
    test_interleaved();
    test_contention();
    test_mid_read_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
